fft4_frame_loader: RTL

Serial-to-parallel input stage for the 4-point FFT core. Accepts one complex sample per cycle over a valid/ready stream, assembles four consecutive samples into a frame, and presents the frame as eight parallel buses that drive the x1..x4 inputs of `fft_4` directly. It has one fill buffer and one output holding register, so the next frame can load while the current one waits for the consumer.

---
 rtl/fft4_frame_loader.sv | 113 +++++++++++
 1 files changed

// File: rtl/fft4_frame_loader.sv
// rtl/fft4_frame_loader.sv - serial-to-parallel loader assembling 4 complex samples into an fft_4 frame
// One fill buffer plus one output holding register, so a new frame loads while the last one waits.
module fft4_frame_loader #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_r,
    input  logic [DATA_WIDTH-1:0] in_i,
    output logic [DATA_WIDTH-1:0] x1_r,
    output logic [DATA_WIDTH-1:0] x1_i,
    output logic [DATA_WIDTH-1:0] x2_r,
    output logic [DATA_WIDTH-1:0] x2_i,
    output logic [DATA_WIDTH-1:0] x3_r,
    output logic [DATA_WIDTH-1:0] x3_i,
    output logic [DATA_WIDTH-1:0] x4_r,
    output logic [DATA_WIDTH-1:0] x4_i,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic [15:0]           frame_cnt
);

    logic [1:0]                 wr_cnt_q, wr_cnt_d;
    logic                       fill_full_q, fill_full_d;
    logic [3:0][DATA_WIDTH-1:0] fill_r_q, fill_r_d;
    logic [3:0][DATA_WIDTH-1:0] fill_i_q, fill_i_d;
    logic [3:0][DATA_WIDTH-1:0] x_r_q, x_r_d;
    logic [3:0][DATA_WIDTH-1:0] x_i_q, x_i_d;
    logic                       frame_valid_q, frame_valid_d;
    logic [15:0]                frame_cnt_q, frame_cnt_d;

    logic accept;
    logic xfer;
    logic handshake;

    // in_ready looks through xfer to frame_ready so a blocked loader resumes the same cycle
    assign xfer      = fill_full_q && (!frame_valid_q || frame_ready);
    assign handshake = frame_valid_q && frame_ready;
    assign in_ready  = !rst && (!fill_full_q || xfer);
    assign accept    = in_valid && in_ready;

    always_comb begin
        wr_cnt_d      = wr_cnt_q;
        fill_full_d   = fill_full_q;
        fill_r_d      = fill_r_q;
        fill_i_d      = fill_i_q;
        x_r_d         = x_r_q;
        x_i_d         = x_i_q;
        frame_valid_d = frame_valid_q;
        frame_cnt_d   = frame_cnt_q;

        if (xfer) begin
            x_r_d         = fill_r_q;
            x_i_d         = fill_i_q;
            frame_valid_d = 1'b1;
            fill_full_d   = 1'b0;
        end else if (handshake) begin
            frame_valid_d = 1'b0;
        end

        // While fill_full is set wr_cnt is 0, so an accept here never collides with the clear above
        if (accept) begin
            fill_r_d[wr_cnt_q] = in_r;
            fill_i_d[wr_cnt_q] = in_i;
            if (wr_cnt_q == 2'd3) begin
                wr_cnt_d    = 2'd0;
                fill_full_d = 1'b1;
            end else begin
                wr_cnt_d = wr_cnt_q + 2'd1;
            end
        end

        if (handshake) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q      <= 2'd0;
            fill_full_q   <= 1'b0;
            fill_r_q      <= '0;
            fill_i_q      <= '0;
            x_r_q         <= '0;
            x_i_q         <= '0;
            frame_valid_q <= 1'b0;
            frame_cnt_q   <= 16'd0;
        end else begin
            wr_cnt_q      <= wr_cnt_d;
            fill_full_q   <= fill_full_d;
            fill_r_q      <= fill_r_d;
            fill_i_q      <= fill_i_d;
            x_r_q         <= x_r_d;
            x_i_q         <= x_i_d;
            frame_valid_q <= frame_valid_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign x1_r        = x_r_q[0];
    assign x1_i        = x_i_q[0];
    assign x2_r        = x_r_q[1];
    assign x2_i        = x_i_q[1];
    assign x3_r        = x_r_q[2];
    assign x3_i        = x_i_q[2];
    assign x4_r        = x_r_q[3];
    assign x4_i        = x_i_q[3];
    assign frame_valid = frame_valid_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
